// File: rtl/xy_wormhole_router.sv
// xy_wormhole_router: 5-port (N,S,E,W,C) wormhole mesh router, row-first XY routing,
// per-packet round-robin output arbitration, one registered stage per output port.
module xy_wormhole_router #(
  parameter int FLIT_W  = 16,
  parameter int COORD_W = 2,
  parameter int MY_ROW  = 0,
  parameter int MY_COL  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5*FLIT_W-1:0] in_flit,
  input  logic [4:0]          in_empty,
  output logic [4:0]          in_read,
  output logic [5*FLIT_W-1:0] out_flit,
  input  logic [4:0]          out_full,
  output logic [4:0]          out_write,
  output logic [4:0]          drop
);

  localparam int NP = 5;
  localparam int PW = 3;
  localparam logic [PW-1:0] P_N = 3'd0, P_S = 3'd1, P_E = 3'd2, P_W = 3'd3, P_C = 3'd4;
  localparam logic [1:0] T_HEAD = 2'b11, T_BODY = 2'b01, T_TAIL = 2'b10;

  logic [FLIT_W-1:0] r_out_flit [NP];
  logic [NP-1:0]     r_out_vld;
  logic [NP-1:0]     r_lock_vld;
  logic [PW-1:0]     r_lock [NP];
  logic [NP-1:0]     r_owner_busy;
  logic [PW-1:0]     r_ptr [NP];

  logic [FLIT_W-1:0] w_flit [NP];
  logic [1:0]        w_typ [NP];
  logic [PW-1:0]     w_route [NP];
  logic [NP-1:0]     w_req_vld;
  logic [PW-1:0]     w_req_dst [NP];
  logic [NP-1:0]     w_drop;
  logic [NP-1:0]     w_out_write;
  logic [NP-1:0]     w_accept;
  logic [NP-1:0]     w_gnt_vld;
  logic [PW-1:0]     w_gnt_src [NP];
  logic [NP-1:0]     w_rd;

  function automatic logic [PW-1:0] f_route(input logic [2*COORD_W-1:0] d);
    logic [COORD_W-1:0] dr;
    logic [COORD_W-1:0] dc;
    dr = d[2*COORD_W-1 -: COORD_W];
    dc = d[COORD_W-1:0];
    if (int'(dr) > MY_ROW)      return P_S;
    else if (int'(dr) < MY_ROW) return P_N;
    else if (int'(dc) > MY_COL) return P_E;
    else if (int'(dc) < MY_COL) return P_W;
    else                        return P_C;
  endfunction

  always_comb begin : p_req
    for (int i = 0; i < NP; i++) begin
      w_flit[i]    = in_flit[i*FLIT_W +: FLIT_W];
      w_typ[i]     = w_flit[i][FLIT_W-1 -: 2];
      w_route[i]   = f_route(w_flit[i][FLIT_W-3 -: 2*COORD_W]);
      w_req_vld[i] = 1'b0;
      w_req_dst[i] = w_route[i];
      w_drop[i]    = 1'b0;
      if (!in_empty[i]) begin
        if (w_typ[i] == T_HEAD) begin
          // A head while locked, or one that would turn back out its own port, is discarded.
          if (r_lock_vld[i] || (w_route[i] == PW'(i) && i != int'(P_C)))
            w_drop[i] = 1'b1;
          else if (!r_owner_busy[w_route[i]])
            w_req_vld[i] = 1'b1;
        end else if (w_typ[i] == T_BODY || w_typ[i] == T_TAIL) begin
          if (r_lock_vld[i]) begin
            w_req_vld[i] = 1'b1;
            w_req_dst[i] = r_lock[i];
          end else begin
            w_drop[i] = 1'b1;
          end
        end else begin
          w_drop[i] = 1'b1;
        end
      end
    end
  end

  assign w_out_write = r_out_vld & ~out_full;
  assign w_accept    = ~r_out_vld | w_out_write;

  // r_ptr holds the highest-priority input for the next head grant (reset: N).
  always_comb begin : p_arb
    int v_idx;
    logic v_found;
    w_gnt_vld = '0;
    w_rd      = '0;
    v_idx     = 0;
    for (int o = 0; o < NP; o++) begin
      w_gnt_src[o] = '0;
      v_found      = 1'b0;
      for (int k = 0; k < NP; k++) begin
        v_idx = (int'(r_ptr[o]) + k) % NP;
        if (!v_found && w_accept[o] && w_req_vld[v_idx] && w_req_dst[v_idx] == PW'(o)) begin
          v_found      = 1'b1;
          w_gnt_src[o] = PW'(v_idx);
        end
      end
      w_gnt_vld[o] = v_found;
      if (v_found) w_rd[w_gnt_src[o]] = 1'b1;
    end
  end

  assign in_read   = rst_n ? (w_rd | w_drop) : '0;
  assign drop      = rst_n ? w_drop : '0;
  assign out_write = w_out_write;

  always_comb begin
    for (int o = 0; o < NP; o++) out_flit[o*FLIT_W +: FLIT_W] = r_out_flit[o];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld    <= '0;
      r_lock_vld   <= '0;
      r_owner_busy <= '0;
      for (int o = 0; o < NP; o++) begin
        r_out_flit[o] <= '0;
        r_lock[o]     <= '0;
        r_ptr[o]      <= '0;
      end
    end else begin
      for (int o = 0; o < NP; o++) begin
        if (w_gnt_vld[o]) begin
          r_out_vld[o]  <= 1'b1;
          r_out_flit[o] <= w_flit[w_gnt_src[o]];
          if (w_typ[w_gnt_src[o]] == T_HEAD) begin
            r_owner_busy[o]           <= 1'b1;
            r_lock_vld[w_gnt_src[o]]  <= 1'b1;
            r_lock[w_gnt_src[o]]      <= PW'(o);
            r_ptr[o] <= (w_gnt_src[o] == P_C) ? P_N : w_gnt_src[o] + PW'(1);
          end else if (w_typ[w_gnt_src[o]] == T_TAIL) begin
            r_owner_busy[o]           <= 1'b0;
            r_lock_vld[w_gnt_src[o]]  <= 1'b0;
          end
        end else if (w_out_write[o]) begin
          r_out_vld[o] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_xy_wormhole_router.sv
// tb_xy_wormhole_router: directed bench for xy_wormhole_router at row 0, column 3.
// Input FIFOs are modelled as queues; written output flits are scoreboarded per port.
module tb_xy_wormhole_router;
  localparam int FW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [5*FW-1:0] in_flit;
  logic [5*FW-1:0] out_flit;
  logic [4:0]    in_empty, in_read, out_full, out_write, drop;

  int checks = 0;
  int errors = 0;

  logic [FW-1:0] q  [5][$];
  logic [FW-1:0] rx [5][$];
  logic [FW-1:0] ex [5][$];
  logic [4:0]    s_read, s_write, s_drop;
  logic [5*FW-1:0] s_flit;

  xy_wormhole_router #(.FLIT_W(16), .COORD_W(2), .MY_ROW(0), .MY_COL(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_flit(in_flit), .in_empty(in_empty), .in_read(in_read),
    .out_flit(out_flit), .out_full(out_full), .out_write(out_write), .drop(drop)
  );

  always #5 clk = ~clk;

  function automatic logic [FW-1:0] hd(input logic [1:0] r, input logic [1:0] c, input logic [9:0] p);
    return {2'b11, r, c, p};
  endfunction
  function automatic logic [FW-1:0] bd(input logic [13:0] p);
    return {2'b01, p};
  endfunction
  function automatic logic [FW-1:0] tl(input logic [13:0] p);
    return {2'b10, p};
  endfunction

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < 5; i++) begin
      in_empty[i] = (q[i].size() == 0);
      in_flit[i*FW +: FW] = (q[i].size() == 0) ? '0 : q[i][0];
    end
  endtask

  // Sample at the falling edge, then pop what was read and present the next heads.
  task automatic cyc();
    @(negedge clk);
    s_read = in_read; s_write = out_write; s_drop = drop; s_flit = out_flit;
    for (int o = 0; o < 5; o++)
      if (out_write[o]) rx[o].push_back(out_flit[o*FW +: FW]);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++)
      if (s_read[i] && q[i].size() > 0) void'(q[i].pop_front());
    apply();
  endtask

  task automatic drain(input int n);
    repeat (n) cyc();
  endtask

  task automatic check_rx(input string tag);
    for (int o = 0; o < 5; o++) begin
      chk($sformatf("%s_count_p%0d", tag, o), 80'(rx[o].size()), 80'(ex[o].size()));
      for (int k = 0; k < ex[o].size() && k < rx[o].size(); k++)
        chk($sformatf("%s_flit_p%0d_%0d", tag, o, k), 80'(rx[o][k]), 80'(ex[o][k]));
      rx[o].delete();
      ex[o].delete();
    end
  endtask

  initial begin
    in_flit = '0; in_empty = '1; out_full = '0;
    #1;
    chk("rst_out_flit", 80'(out_flit), 80'(0));
    chk("rst_out_write", 80'(out_write), 80'(0));
    in_empty[4] = 1'b0;
    in_flit[4*FW +: FW] = hd(2'd0, 2'd3, 10'h001);
    #1;
    chk("rst_in_read", 80'(in_read), 80'(0));
    chk("rst_drop", 80'(drop), 80'(0));
    in_empty = '1; in_flit = '0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    apply();

    // 1: W -> C packet, then C output is free for another input
    q[3].push_back(hd(2'd0, 2'd3, 10'h011)); q[3].push_back(bd(14'h012)); q[3].push_back(tl(14'h013));
    apply();
    cyc(); chk("t1_c0_read", 80'(s_read), 80'(5'b01000));
    cyc(); chk("t1_c1_write", 80'(s_write), 80'(5'b10000));
           chk("t1_c1_flit", 80'(s_flit[4*FW +: FW]), 80'(hd(2'd0, 2'd3, 10'h011)));
    cyc(); chk("t1_c2_flit", 80'(s_flit[4*FW +: FW]), 80'(bd(14'h012)));
           chk("t1_c2_write", 80'(s_write), 80'(5'b10000));
    cyc(); chk("t1_c3_flit", 80'(s_flit[4*FW +: FW]), 80'(tl(14'h013)));
           chk("t1_c3_read", 80'(s_read), 80'(5'b00000));
    q[0].push_back(hd(2'd0, 2'd3, 10'h014)); q[0].push_back(tl(14'h015));
    apply();
    cyc(); chk("t1_owner_free", 80'(s_read), 80'(5'b00001));
    drain(4);
    ex[4].push_back(hd(2'd0, 2'd3, 10'h011)); ex[4].push_back(bd(14'h012)); ex[4].push_back(tl(14'h013));
    ex[4].push_back(hd(2'd0, 2'd3, 10'h014)); ex[4].push_back(tl(14'h015));
    check_rx("t1");

    // 2: routing N->S, C->W, E->S (row first); E waits for N's packet on S
    q[0].push_back(hd(2'd2, 2'd3, 10'h021)); q[0].push_back(tl(14'h022));
    q[4].push_back(hd(2'd0, 2'd1, 10'h023)); q[4].push_back(tl(14'h024));
    q[2].push_back(hd(2'd1, 2'd0, 10'h025)); q[2].push_back(tl(14'h026));
    apply();
    cyc(); chk("t2_c0_read", 80'(s_read), 80'(5'b10001));
    drain(7);
    ex[1].push_back(hd(2'd2, 2'd3, 10'h021)); ex[1].push_back(tl(14'h022));
    ex[1].push_back(hd(2'd1, 2'd0, 10'h025)); ex[1].push_back(tl(14'h026));
    ex[3].push_back(hd(2'd0, 2'd1, 10'h023)); ex[3].push_back(tl(14'h024));
    check_rx("t2");

    // 3: N and S contend for W (E is unreachable from column 3 with 2-bit columns).
    // N wins first; after N's tail, S beats N's second head.
    q[0].push_back(hd(2'd0, 2'd1, 10'h031)); q[0].push_back(bd(14'h032)); q[0].push_back(tl(14'h033));
    q[0].push_back(hd(2'd0, 2'd1, 10'h037)); q[0].push_back(tl(14'h038));
    q[1].push_back(hd(2'd0, 2'd1, 10'h034)); q[1].push_back(bd(14'h035)); q[1].push_back(tl(14'h036));
    apply();
    cyc(); chk("t3_c0_read", 80'(s_read), 80'(5'b00001));
    cyc(); cyc();
    cyc(); chk("t3_c3_read", 80'(s_read), 80'(5'b00010));
    cyc(); cyc();
    cyc(); chk("t3_c6_read", 80'(s_read), 80'(5'b00001));
    drain(5);
    ex[3].push_back(hd(2'd0, 2'd1, 10'h031)); ex[3].push_back(bd(14'h032)); ex[3].push_back(tl(14'h033));
    ex[3].push_back(hd(2'd0, 2'd1, 10'h034)); ex[3].push_back(bd(14'h035)); ex[3].push_back(tl(14'h036));
    ex[3].push_back(hd(2'd0, 2'd1, 10'h037)); ex[3].push_back(tl(14'h038));
    check_rx("t3");

    // 4: backpressure on W mid-packet
    q[4].push_back(hd(2'd0, 2'd1, 10'h041)); q[4].push_back(bd(14'h042)); q[4].push_back(bd(14'h043));
    q[4].push_back(bd(14'h044)); q[4].push_back(tl(14'h045));
    apply();
    cyc(); cyc();
    out_full[3] = 1'b1;
    cyc(); chk("t4_c2_write", 80'(s_write), 80'(5'b00000));
           chk("t4_c2_read", 80'(s_read), 80'(5'b00000));
           chk("t4_c2_flit", 80'(s_flit[3*FW +: FW]), 80'(bd(14'h042)));
    cyc(); chk("t4_c3_flit", 80'(s_flit[3*FW +: FW]), 80'(bd(14'h042)));
           chk("t4_c3_read", 80'(s_read), 80'(5'b00000));
    out_full[3] = 1'b0;
    cyc(); chk("t4_c4_write", 80'(s_write), 80'(5'b01000));
    drain(6);
    ex[3].push_back(hd(2'd0, 2'd1, 10'h041)); ex[3].push_back(bd(14'h042)); ex[3].push_back(bd(14'h043));
    ex[3].push_back(bd(14'h044)); ex[3].push_back(tl(14'h045));
    check_rx("t4");

    // 5: malformed flits
    q[1].push_back(bd(14'h051));
    q[0].push_back(16'h0000);
    apply();
    cyc(); chk("t5_nohead_read", 80'(s_read), 80'(5'b00011));
           chk("t5_nohead_drop", 80'(s_drop), 80'(5'b00011));
    cyc(); chk("t5_nohead_write", 80'(s_write), 80'(5'b00000));
    q[1].push_back(hd(2'd1, 2'd3, 10'h052));
    apply();
    cyc(); chk("t5_uturn_drop", 80'(s_drop), 80'(5'b00010));
           chk("t5_uturn_read", 80'(s_read), 80'(5'b00010));
    cyc(); chk("t5_uturn_write", 80'(s_write), 80'(5'b00000));
    q[3].push_back(hd(2'd0, 2'd3, 10'h061)); q[3].push_back(hd(2'd0, 2'd3, 10'h062));
    q[3].push_back(tl(14'h063));
    apply();
    cyc(); chk("t5_lock_c0_drop", 80'(s_drop), 80'(5'b00000));
    cyc(); chk("t5_lock_c1_drop", 80'(s_drop), 80'(5'b01000));
    cyc(); chk("t5_lock_c2_read", 80'(s_read), 80'(5'b01000));
           chk("t5_lock_c2_drop", 80'(s_drop), 80'(5'b00000));
    drain(3);
    ex[4].push_back(hd(2'd0, 2'd3, 10'h061)); ex[4].push_back(tl(14'h063));
    check_rx("t5");

    // 6: asynchronous reset mid-packet, then a fresh packet
    q[4].push_back(hd(2'd0, 2'd1, 10'h071)); q[4].push_back(bd(14'h072));
    apply();
    cyc(); cyc();
    q[4].push_back(hd(2'd0, 2'd1, 10'h081)); q[4].push_back(tl(14'h082));
    apply();
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_flit", 80'(out_flit), 80'(0));
    chk("t6_rst_write", 80'(out_write), 80'(0));
    chk("t6_rst_read", 80'(in_read), 80'(0));
    chk("t6_rst_drop", 80'(drop), 80'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(); chk("t6_fresh_read", 80'(s_read), 80'(5'b10000));
           chk("t6_fresh_drop", 80'(s_drop), 80'(5'b00000));
    drain(4);
    ex[3].push_back(hd(2'd0, 2'd1, 10'h071));
    ex[3].push_back(hd(2'd0, 2'd1, 10'h081)); ex[3].push_back(tl(14'h082));
    check_rx("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
